// File: rtl/cprv_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cprv_mem_port_arbiter
//  Function : Arbitrates the fetch and data requesters onto one memory port and
//             routes in-order responses back through a tag FIFO.
//             Optional round-robin arbitration: define CPRV_ARB_RR_EN.
//  Revision : 1.0  initial release
// ============================================================================
module cprv_mem_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_OUTST  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_valid_i,
    output logic                    if_ready_o,
    input  logic [DATA_WIDTH-1:0]   if_addr_i,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    dm_valid_i,
    output logic                    dm_ready_o,
    input  logic [DATA_WIDTH-1:0]   dm_addr_i,
    input  logic                    dm_we_i,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dm_wstrb_i,
    output logic                    dm_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dm_rdata_o,
    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic [DATA_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int   PTR_W  = $clog2(MAX_OUTST);
    localparam int   CNT_W  = PTR_W + 1;
    localparam int   STRB_W = DATA_WIDTH / 8;
    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t            lock_q, lock_d;
    logic                   sel_q, sel_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [MAX_OUTST-1:0]   tag_q, tag_d;

    logic w_win_dm;
    logic w_win_valid;
    logic w_full;
    logic w_push;
    logic w_pop;

`ifdef CPRV_ARB_RR_EN
    logic rr_last_q, rr_last_d;
`endif

    // Winner: a held lock wins outright; otherwise DM priority or round-robin.
    always_comb begin
        if (lock_q == ST_LOCKED) begin
            w_win_dm = sel_q;
        end else if (dm_valid_i && if_valid_i) begin
`ifdef CPRV_ARB_RR_EN
            w_win_dm = ~rr_last_q;
`else
            w_win_dm = SEL_DM;
`endif
        end else begin
            w_win_dm = dm_valid_i;
        end
    end

    assign w_win_valid = w_win_dm ? dm_valid_i : if_valid_i;
    assign w_full      = (cnt_q == CNT_W'(MAX_OUTST));
    assign mem_valid_o = rst_n & w_win_valid & ~w_full;
    assign w_push      = mem_valid_o & mem_ready_i;
    assign if_ready_o  = w_push & ~w_win_dm;
    assign dm_ready_o  = w_push & w_win_dm;

    assign mem_addr_o  = w_win_dm ? dm_addr_i  : if_addr_i;
    assign mem_we_o    = w_win_dm & dm_we_i;
    assign mem_wdata_o = w_win_dm ? dm_wdata_i : '0;
    assign mem_wstrb_o = w_win_dm ? dm_wstrb_i : {STRB_W{1'b0}};

    // A response with nothing outstanding is dropped rather than routed.
    assign w_pop       = mem_rvalid_i & (cnt_q != '0);
    assign if_rvalid_o = w_pop & ~tag_q[rd_ptr_q];
    assign dm_rvalid_o = w_pop & tag_q[rd_ptr_q];
    assign if_rdata_o  = mem_rdata_i;
    assign dm_rdata_o  = mem_rdata_i;

    always_comb begin
        lock_d   = lock_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        tag_d    = tag_q;

        case (lock_q)
            ST_UNLOCKED: begin
                if (mem_valid_o && !mem_ready_i) begin
                    lock_d = ST_LOCKED;
                    sel_d  = w_win_dm;
                end
            end
            default: begin
                // Held requester withdrawing also releases the lock.
                if (w_push || !w_win_valid) begin
                    lock_d = ST_UNLOCKED;
                end
            end
        endcase

        if (w_push) begin
            tag_d[wr_ptr_q] = w_win_dm;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push && !w_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!w_push && w_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q   <= ST_UNLOCKED;
            sel_q    <= SEL_DM;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            tag_q    <= '0;
        end else begin
            lock_q   <= lock_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            tag_q    <= tag_d;
        end
    end

`ifdef CPRV_ARB_RR_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if (w_push) begin
            rr_last_d = w_win_dm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= SEL_DM;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(mem_rvalid_i && (cnt_q == '0)));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cprv_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cprv_mem_port_arbiter
//  Function : Vector table, directed sequences and a queue-based reference
//             model driven by random traffic.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cprv_mem_port_arbiter;

    localparam int DW = 64;
    localparam int MO = 4;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_valid_i, if_ready_o, if_rvalid_o;
    logic [DW-1:0] if_addr_i, if_rdata_o;
    logic          dm_valid_i, dm_ready_o, dm_we_i, dm_rvalid_o;
    logic [DW-1:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic [SW-1:0] dm_wstrb_i, mem_wstrb_o;
    logic          mem_valid_o, mem_ready_i, mem_we_o, mem_rvalid_i;
    logic [DW-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    always #5 clk = ~clk;

    cprv_mem_port_arbiter #(.DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_addr_i(if_addr_i),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_valid_i(dm_valid_i), .dm_ready_o(dm_ready_o), .dm_addr_i(dm_addr_i),
        .dm_we_i(dm_we_i), .dm_wdata_i(dm_wdata_i), .dm_wstrb_i(dm_wstrb_i),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic iv, input logic dv, input logic we, input logic rdy,
                         input logic rv, input logic [DW-1:0] ia, input logic [DW-1:0] da,
                         input logic [DW-1:0] rd);
        @(negedge clk);
        if_valid_i   = iv;
        dm_valid_i   = dv;
        dm_we_i      = we;
        mem_ready_i  = rdy;
        mem_rvalid_i = rv;
        if_addr_i    = ia;
        dm_addr_i    = da;
        mem_rdata_i  = rd;
        dm_wdata_i   = {$urandom, $urandom};
        dm_wstrb_i   = SW'($urandom);
        #1;
    endtask

    // Reference model: outstanding-tag queue, held requester, last grant.
    bit m_q[$];
    int m_held;
    bit m_rr_last;

    task automatic model_reset();
        m_q.delete();
        m_held    = -1;
        m_rr_last = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        if_valid_i = 1'b1; dm_valid_i = 1'b1; mem_ready_i = 1'b1; mem_rvalid_i = 1'b0;
        dm_we_i = 1'b0; if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; dm_wstrb_i = '0;
        mem_rdata_i = '0;
        #1;
        chk("reset_outputs", {60'd0, mem_valid_o, if_ready_o, dm_ready_o, if_rvalid_o | dm_rvalid_o}, '0);
        @(negedge clk);
        if_valid_i = 1'b0; dm_valid_i = 1'b0; mem_ready_i = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic model_step();
        bit w, wv, full, emv, hs, pop, head;
        if (m_held >= 0)
            w = (m_held == 1);
        else if (dm_valid_i && if_valid_i)
`ifdef CPRV_ARB_RR_EN
            w = !m_rr_last;
`else
            w = 1'b1;
`endif
        else
            w = dm_valid_i;
        wv   = w ? dm_valid_i : if_valid_i;
        full = (m_q.size() == MO);
        emv  = wv && !full;
        hs   = emv && mem_ready_i;
        pop  = mem_rvalid_i && (m_q.size() > 0);
        head = (m_q.size() > 0) ? m_q[0] : 1'b0;
        chk("rnd_mem_valid", DW'(mem_valid_o), DW'(emv));
        chk("rnd_if_ready",  DW'(if_ready_o),  DW'(hs && !w));
        chk("rnd_dm_ready",  DW'(dm_ready_o),  DW'(hs && w));
        chk("rnd_if_rvalid", DW'(if_rvalid_o), DW'(pop && !head));
        chk("rnd_dm_rvalid", DW'(dm_rvalid_o), DW'(pop && head));
        if (pop) chk("rnd_rdata", w ? dm_rdata_o : if_rdata_o, mem_rdata_i);
        if (emv) begin
            chk("rnd_addr",  mem_addr_o, w ? dm_addr_i : if_addr_i);
            chk("rnd_we",    DW'(mem_we_o), DW'(w && dm_we_i));
            chk("rnd_wstrb", DW'(mem_wstrb_o), w ? DW'(dm_wstrb_i) : '0);
        end
        if (pop) void'(m_q.pop_front());
        if (hs) begin
            m_q.push_back(w);
            m_rr_last = w;
        end
        if (m_held < 0) begin
            if (emv && !mem_ready_i) m_held = w ? 1 : 0;
        end else if (hs || !wv) begin
            m_held = -1;
        end
    endtask

    typedef struct {
        logic iv, dv, we, rdy, rv;
        logic [5:0] exp;  // {mem_valid, if_ready, dm_ready, if_rvalid, dm_rvalid, mem_we}
        logic [DW-1:0] exp_addr;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic dv, input logic we, input logic rdy,
                                input logic rv, input logic [5:0] e, input logic [DW-1:0] a);
        vec_t v;
        v.iv = iv; v.dv = dv; v.we = we; v.rdy = rdy; v.rv = rv; v.exp = e; v.exp_addr = a;
        return v;
    endfunction

    localparam logic [DW-1:0] IA = 64'h1000;
    localparam logic [DW-1:0] DA = 64'h2000;

    initial begin
        vec_t tbl[22];
        logic [DW-1:0] rd;
        logic [DW-1:0] ia_hold, da_hold;
        logic we_hold;
        logic [DW-1:0] wd_hold;
        logic [SW-1:0] ws_hold;

        //               iv dv we rdy rv  mv ir dr irv drv we
        tbl[0]  = mk(0, 0, 0, 0, 0, 6'b000000, '0);
        tbl[1]  = mk(1, 1, 0, 1, 0, 6'b101000, DA);
        tbl[2]  = mk(1, 1, 0, 1, 0, 6'b101000, DA);
        tbl[3]  = mk(0, 0, 0, 0, 1, 6'b000010, '0);
        tbl[4]  = mk(0, 0, 0, 0, 1, 6'b000010, '0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 6'b100000, IA);
        tbl[6]  = mk(1, 1, 0, 0, 0, 6'b100000, IA);
        tbl[7]  = mk(1, 1, 0, 1, 0, 6'b110000, IA);
        tbl[8]  = mk(0, 1, 0, 1, 0, 6'b101000, DA);
        tbl[9]  = mk(0, 1, 1, 1, 0, 6'b101001, DA);
        tbl[10] = mk(1, 0, 0, 1, 0, 6'b110000, IA);
        tbl[11] = mk(1, 1, 0, 1, 0, 6'b000000, '0);
        tbl[12] = mk(1, 0, 0, 1, 1, 6'b000100, '0);
        tbl[13] = mk(1, 0, 0, 1, 0, 6'b110000, IA);
        tbl[14] = mk(0, 0, 0, 0, 1, 6'b000010, '0);
        tbl[15] = mk(0, 0, 0, 0, 1, 6'b000010, '0);
        tbl[16] = mk(0, 0, 0, 0, 1, 6'b000100, '0);
        tbl[17] = mk(0, 0, 0, 0, 1, 6'b000100, '0);
        tbl[18] = mk(0, 1, 0, 0, 0, 6'b100000, DA);
        tbl[19] = mk(1, 0, 0, 0, 0, 6'b000000, '0);
        tbl[20] = mk(1, 0, 0, 1, 0, 6'b110000, IA);
        tbl[21] = mk(0, 0, 0, 0, 1, 6'b000100, '0);

        rst_n = 1'b1;
        do_reset();

`ifndef CPRV_ARB_RR_EN
        for (int i = 0; i < 22; i++) begin
            rd = {$urandom, $urandom};
            drive(tbl[i].iv, tbl[i].dv, tbl[i].we, tbl[i].rdy, tbl[i].rv, IA, DA, rd);
            chk($sformatf("vec%0d_flags", i),
                DW'({mem_valid_o, if_ready_o, dm_ready_o, if_rvalid_o, dm_rvalid_o,
                     mem_valid_o & mem_we_o}),
                DW'(tbl[i].exp));
            if (tbl[i].exp[5]) chk($sformatf("vec%0d_addr", i), mem_addr_o, tbl[i].exp_addr);
            if (tbl[i].rv) chk($sformatf("vec%0d_rdata", i), if_rdata_o, rd);
        end
`else
        // Contention alternates starting with IF, since the last grant resets to DM.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 1, 0, IA, DA, '0);
            chk($sformatf("rr%0d_if_ready", i), DW'(if_ready_o), DW'(i % 2 == 0));
            chk($sformatf("rr%0d_dm_ready", i), DW'(dm_ready_o), DW'(i % 2 == 1));
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, IA, DA, '0);
`endif

        // Responses return in issue order to the right requester.
        do_reset();
        drive(1, 0, 0, 1, 0, 64'h1000, DA, '0);
        chk("route_if0_ready", DW'(if_ready_o), 64'd1);
        chk("route_if0_addr", mem_addr_o, 64'h1000);
        drive(0, 1, 0, 1, 0, IA, 64'h2000, '0);
        chk("route_dm_ready", DW'(dm_ready_o), 64'd1);
        drive(1, 0, 0, 1, 0, 64'h1004, DA, '0);
        chk("route_if1_addr", mem_addr_o, 64'h1004);
        drive(0, 0, 0, 0, 1, IA, DA, 64'hAAAA_0000_0000_000A);
        chk("route_A", DW'({if_rvalid_o, dm_rvalid_o}), 64'd2);
        chk("route_A_data", if_rdata_o, 64'hAAAA_0000_0000_000A);
        drive(0, 0, 0, 0, 1, IA, DA, 64'hBBBB_0000_0000_000B);
        chk("route_B", DW'({if_rvalid_o, dm_rvalid_o}), 64'd1);
        chk("route_B_data", dm_rdata_o, 64'hBBBB_0000_0000_000B);
        drive(0, 0, 0, 0, 1, IA, DA, 64'hCCCC_0000_0000_000C);
        chk("route_C", DW'({if_rvalid_o, dm_rvalid_o}), 64'd2);

        // Reset with a DM tag outstanding must discard it.
        drive(0, 1, 0, 1, 0, IA, DA, '0);
        chk("midrst_dm_ready", DW'(dm_ready_o), 64'd1);
        do_reset();
        drive(1, 0, 0, 1, 0, IA, DA, '0);
        chk("midrst_if_ready", DW'(if_ready_o), 64'd1);
        drive(0, 0, 0, 0, 1, IA, DA, 64'h5);
        chk("midrst_route", DW'({if_rvalid_o, dm_rvalid_o}), 64'd2);

        // Random traffic against the model; held requesters keep their fields.
        do_reset();
        ia_hold = '0; da_hold = '0; we_hold = 1'b0; wd_hold = '0; ws_hold = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (m_held == 0) begin
                if_valid_i = ($urandom_range(0, 15) != 0);
            end else begin
                if_valid_i = $urandom_range(0, 1) == 1;
                ia_hold = {$urandom, $urandom};
            end
            if (m_held == 1) begin
                dm_valid_i = ($urandom_range(0, 15) != 0);
            end else begin
                dm_valid_i = $urandom_range(0, 1) == 1;
                da_hold = {$urandom, $urandom};
                we_hold = $urandom_range(0, 1) == 1;
                wd_hold = {$urandom, $urandom};
                ws_hold = SW'($urandom);
            end
            if_addr_i    = ia_hold;
            dm_addr_i    = da_hold;
            dm_we_i      = we_hold;
            dm_wdata_i   = wd_hold;
            dm_wstrb_i   = ws_hold;
            mem_ready_i  = ($urandom_range(0, 2) != 0);
            mem_rvalid_i = (m_q.size() > 0) && ($urandom_range(0, 4) < 2);
            mem_rdata_i  = {$urandom, $urandom};
            #1;
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
